// File: rtl/alu_seq_unit.sv
// Registered MIPS ALU with built-in ALU-control decode; iterative shift-right and an
// optional shift-add multiplier (enabled by defining ALU_MUL_EN) behind a valid/ready/done handshake.
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       aluop,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [2:0]       op
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
`ifdef ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b100;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic [SW-1:0]    r_cnt;
    logic [2:0]       w_dec_op;
    logic [WIDTH-1:0] w_alu_res;
    logic [SW-1:0]    w_shamt;
    logic             w_accept;
    logic             w_shr_long;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_mul_sum;
    logic             w_is_mul;
`endif

    assign w_accept   = in_valid & ready;
    assign w_shamt    = b[SW-1:0];
    assign w_shr_long = (w_dec_op == OP_SHR) && (w_shamt > SW'(1));
`ifdef ALU_MUL_EN
    assign w_is_mul   = (w_dec_op == OP_MUL);
    assign w_mul_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

    // R-type rules are applied in priority order; a later matching rule overrides earlier ones.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_dec_op = OP_ADD;
        if (!aluop[1]) begin
            w_dec_op = aluop[0] ? OP_SUB : OP_ADD;
        end else begin
            if (funct == 4'b0000)         w_dec_op = OP_ADD;
            if (funct[3] && funct[1])     w_dec_op = OP_SLT;
            if (!funct[3] && funct[1])    w_dec_op = OP_SUB;
            if (funct[2] && funct[0])     w_dec_op = OP_OR;
            if (funct[2] && !funct[0])    w_dec_op = OP_AND;
            if (funct == 4'b0110)         w_dec_op = OP_SHR;
`ifdef ALU_MUL_EN
            if (funct == 4'b1000)         w_dec_op = OP_MUL;
`endif
        end
    end

    // Shift amounts 0 and 1 finish at accept, so only those two shr results are needed here.
    always_comb begin
        w_alu_res = a + b;
        case (w_dec_op)
            OP_SUB:  w_alu_res = a - b;
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SHR:  w_alu_res = (w_shamt == '0) ? a : (a >> 1);
            default: w_alu_res = a + b;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_shr_long) w_next_state = S_SHIFT;
`ifdef ALU_MUL_EN
                if (w_accept && w_is_mul)   w_next_state = S_MUL;
`endif
            end
            S_SHIFT: if (r_cnt == SW'(1)) w_next_state = S_IDLE;
`ifdef ALU_MUL_EN
            S_MUL:   if (r_cnt == SW'(1)) w_next_state = S_IDLE;
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    // The done cycle itself blocks a new accept, so single-cycle ops issue every other cycle.
    always_comb begin
        ready = (r_state == S_IDLE) && !done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            result   <= '0;
            zero     <= 1'b1;
            done     <= 1'b0;
            op       <= OP_ADD;
`ifdef ALU_MUL_EN
            r_mcand  <= '0;
            r_mplier <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout, so the default below is cleanly overridden on completion.
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    op <= w_dec_op;
                    if (w_shr_long) begin
                        r_acc <= a >> 1;
                        r_cnt <= w_shamt - SW'(1);
`ifdef ALU_MUL_EN
                    end else if (w_is_mul) begin
                        // First partial product is folded into the accept cycle.
                        r_acc    <= b[0] ? a : '0;
                        r_mcand  <= a << 1;
                        r_mplier <= b >> 1;
                        r_cnt    <= SW'(WIDTH - 1);
`endif
                    end else begin
                        result <= w_alu_res;
                        zero   <= (w_alu_res == '0);
                        done   <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_acc <= r_acc >> 1;
                    r_cnt <= r_cnt - SW'(1);
                    if (r_cnt == SW'(1)) begin
                        result <= r_acc >> 1;
                        zero   <= ((r_acc >> 1) == '0);
                        done   <= 1'b1;
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    r_acc    <= w_mul_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - SW'(1);
                    if (r_cnt == SW'(1)) begin
                        result <= w_mul_sum;
                        zero   <= (w_mul_sum == '0);
                        done   <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, registered ALU with integrated ALU-control decode for the MIPS datapath. It takes the main-control ALUOp pair and the low four function-code bits, decodes the operation, and executes it. Single-cycle ops complete in one cycle. Logical shift-right runs iteratively, one bit per cycle, and an optional shift-add multiplier takes WIDTH cycles. A valid/ready/done handshake lets the multicycle controller stall on long operations.

## Interface
- WIDTH, 32: datapath width; power of two, ≥ 4. Let SW = log2(WIDTH).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- aluop  input  2  {aluop1, aluop0} from main control.
- funct  input  4  function code bits {f3, f2, f1, f0}.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt/immediate); b[SW-1:0] is the shift amount.
- in_valid  input  1  request; accepted only when ready = 1.
- ready  output  1  unit idle and able to accept.
- done  output  1  one-cycle pulse: result/zero/op updated this cycle.
- result  output  WIDTH  last completed result, held until the next completion.
- zero  output  1  result == 0, registered with result.
- op  output  3  ALU control code of the last accepted operation.

## Operation
- Decode (combinational, on accept):
  - aluop = 00 → 010 (add).
  - aluop = 01 → 110 (sub).
  - aluop1 = 1 → R-type. Conditions are evaluated in this order, and the last true one wins:
    - default add 010;
    - ~f3&~f2&~f1&~f0 → 010;
    - f3&f1 → 111 (slt);
    - ~f3&f1 → 110 (sub);
    - f2&f0 → 001 (or);
    - f2&~f0 → 000 (and);
    - ~f3&f2&f1&~f0 → 011 (shr);
    - funct = 1000 → 100 (mul, only with ALU_MUL_EN).
  - Unmatched codes yield add. No latched state.
- Ops:
  - add/sub: modulo 2^WIDTH.
  - and, or: bitwise.
  - slt: signed compare; result is {WIDTH-1 zeros, a<b}.
  - shr: logical a >> b[SW-1:0].
  - mul: low WIDTH bits of a*b.
- FSM states: IDLE, SHIFT, MUL.
  - IDLE, accept of add/sub/and/or/slt, or shr with shamt = 0: compute and register result/zero, pulse done next cycle, stay IDLE.
  - IDLE, accept of shr with shamt ≥ 1: acc ← a >> 1, cnt ← shamt − 1.
    - If cnt = 0, complete immediately.
    - Otherwise go to SHIFT. Each cycle acc ← acc >> 1 and cnt ← cnt − 1; on reaching 0, complete and return to IDLE.
  - IDLE, accept of mul: go to MUL, mcand ← a, mplier ← b, acc ← 0, cnt ← WIDTH.
    - Each cycle: if mplier[0], acc ← acc + mcand; then mcand ← mcand << 1, mplier ← mplier >> 1, cnt − 1.
    - Complete after WIDTH iterations.
- ready = 1 only in IDLE with no completion pending in that cycle. Operands are captured at accept and may change afterwards.
- in_valid while ready = 0 is ignored; there is no queueing.
- op is registered at accept.

## Timing
- Reset values: result = 0, zero = 1, done = 0, ready = 1, op = 010, FSM = IDLE, all counters 0.
- Define accept edge k as the edge where in_valid & ready.
- Latency: done is high in cycle k+L, where L is:
  - 1 for single-cycle ops and shr with shamt = 0;
  - shamt for shr with shamt ≥ 1;
  - WIDTH for mul.
- ready is low from k+1 through k+L inclusive, and high again at k+L+1. Back-to-back single-cycle ops therefore accept every other cycle.
- result/zero change only on the done cycle.
- rst_n asserted mid-operation: immediate abort, all outputs return to reset values, no done pulse; the first accept is possible on the first edge after release.
- shamt = WIDTH−1 (maximum): L = WIDTH−1.

## Configuration
- ALU_MUL_EN defined: MUL state and shift-add datapath are present; funct 1000 with aluop1 = 1 decodes to 100.
- Not defined: no MUL logic; funct 1000 decodes to add (010), L = 1.

## Test plan
- Reset: hold rst_n = 0 → result = 0, zero = 1, ready = 1, done = 0, op = 010.
- aluop = 10, funct = 0010, a = 5, b = 7, WIDTH = 32 → done at k+1, result = 0xFFFFFFFE, zero = 0, op = 110. Repeat with funct = 1010, a = 0xFFFFFFFF, b = 1 → result = 1 (signed slt).
- aluop = 10, funct = 0110, a = 0x80000000, b = 31 → ready low for 31 cycles, done at k+31, result = 1. With b = 0 → done at k+1, result = a.
- With ALU_MUL_EN: funct = 1000, a = 0x10001, b = 0x10001 → done at k+32, result = 0x00020001. Without the macro: same stimulus → done at k+1, result = 0x20002, op = 010.
- During a shr with b = 20, pulse in_valid at k+5 → ignored, no extra done; at k+10 drive rst_n = 0 → outputs reset, no done.
- aluop = 01, a = b = 0x1234 → result = 0, zero = 1. aluop = 10, funct = 1111 → op = 001 (or wins); funct = 1110 → op = 000.
